// File: rtl/ed25519_sign_arbiter.sv
// ed25519_sign_arbiter
// Round-robin arbiter that shares one Ed25519 signing core among NUM_REQ
// requesters. The winning requester's operands are latched, the core is
// started with a one-cycle pulse, and the result comes back to the winner
// as a one-cycle strobe tagged with its id.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req[NUM_REQ]             request levels, one per requester
//   req_sk/req_pk/req_msg    packed operands, slice i = [256*i +: 256]
//   gnt[NUM_REQ]             one-hot grant, operand latch through DONE
//   res_valid/res_id/res_err one-cycle result strobe, owner id, abort flag
//   res_r/res_s              signature halves (zero on abort)
//   core_sk/core_pk/core_m   registered operands to the signing core
//   core_ena                 registered one-cycle start pulse
//   core_ready               core idle and able to accept a start
//   core_comp_done           core completion pulse, core_r/core_s valid
//
// Optional feature: define ED25519_SIGN_ARB_TIMEOUT_EN to add a BUSY
// watchdog of TIMEOUT_CYCLES cycles that ends the operation with res_err=1.
module ed25519_sign_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*256-1:0] req_sk,
    input  logic [NUM_REQ*256-1:0] req_pk,
    input  logic [NUM_REQ*256-1:0] req_msg,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   res_valid,
    output logic [2:0]             res_id,
    output logic [255:0]           res_r,
    output logic [255:0]           res_s,
    output logic                   res_err,
    output logic [255:0]           core_sk,
    output logic [255:0]           core_pk,
    output logic [255:0]           core_m,
    output logic                   core_ena,
    input  logic                   core_ready,
    input  logic                   core_comp_done,
    input  logic [255:0]           core_r,
    input  logic [255:0]           core_s
);

    typedef enum logic [1:0] {IDLE, WAIT_RDY, BUSY, DONE} state_t;

    state_t               state;
    logic [2:0]           rr_ptr;
    logic [2:0]           winner;
    logic [2:0]           pick;
    logic                 found;
    logic [3:0]           idx;
    logic [7:0]           req_ext;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [255:0]         sel_sk, sel_pk, sel_m;
    logic [2:0]           rr_next;

    // Zero-extend so the rotating index can address any NUM_REQ up to 8.
    assign req_ext = 8'(req);

    // First set request at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
            if (!found && req_ext[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    // Operand mux with constant slices, keyed by the winning index.
    always_comb begin
        pick_oh = '0;
        sel_sk  = '0;
        sel_pk  = '0;
        sel_m   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == 3'(i)) begin
                pick_oh[i] = 1'b1;
                sel_sk     = req_sk[256*i +: 256];
                sel_pk     = req_pk[256*i +: 256];
                sel_m      = req_msg[256*i +: 256];
            end
        end
    end

    assign rr_next = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;

`ifdef ED25519_SIGN_ARB_TIMEOUT_EN
    logic [23:0] tmo_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    // Without the watchdog an operation can never abort.
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_r     <= '0;
            res_s     <= '0;
            core_sk   <= '0;
            core_pk   <= '0;
            core_m    <= '0;
            core_ena  <= 1'b0;
`ifdef ED25519_SIGN_ARB_TIMEOUT_EN
            res_err   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            core_ena  <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt     <= pick_oh;
                        winner  <= pick;
                        core_sk <= sel_sk;
                        core_pk <= sel_pk;
                        core_m  <= sel_m;
                        state   <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (core_ready) begin
                        core_ena <= 1'b1;
                        state    <= BUSY;
`ifdef ED25519_SIGN_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                BUSY: begin
                    // A completion on the watchdog's final cycle still wins.
                    if (core_comp_done) begin
                        res_r     <= core_r;
                        res_s     <= core_s;
                        res_valid <= 1'b1;
                        res_id    <= winner;
                        state     <= DONE;
`ifdef ED25519_SIGN_ARB_TIMEOUT_EN
                        res_err   <= 1'b0;
                    end else if (tmo_cnt == TIMEOUT_CYCLES - 24'd1) begin
                        res_r     <= '0;
                        res_s     <= '0;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_id    <= winner;
                        state     <= DONE;
                    end else begin
                        tmo_cnt   <= tmo_cnt + 24'd1;
`endif
                    end
                end
                DONE: begin
                    gnt    <= '0;
                    rr_ptr <= rr_next;
                    res_r  <= '0;
                    res_s  <= '0;
`ifdef ED25519_SIGN_ARB_TIMEOUT_EN
                    res_err <= 1'b0;
`endif
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ed25519_sign_arbiter.sv
// Directed bench for ed25519_sign_arbiter with a behavioural signing-core
// stub: r = sk ^ m, s = pk + 1, delivered stub_delay cycles after core_ena.
module tb_ed25519_sign_arbiter;

`ifdef ED25519_SIGN_ARB_TIMEOUT_EN
    localparam logic [23:0] TMO = 24'd100;
`else
    localparam logic [23:0] TMO = 24'd1000000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = '0;
    logic [1023:0] req_sk = '0, req_pk = '0, req_msg = '0;
    logic [3:0]    gnt;
    logic          res_valid, res_err;
    logic [2:0]    res_id;
    logic [255:0]  res_r, res_s, core_sk, core_pk, core_m;
    logic          core_ena;
    logic          core_ready = 1'b1;
    logic          core_comp_done;
    logic [255:0]  core_r = '0, core_s = '0;

    logic          stub_done = 1'b0;
    logic          spur = 1'b0;
    int            stub_delay = 50;
    bit            stub_hang = 1'b0;
    int            stub_cnt = 0;
    int            ena_cnt = 0, ena_dbl = 0;
    logic          ena_prev = 1'b0;
    int            checks = 0, fails = 0;

    assign core_comp_done = stub_done | spur;

    always #5 clk = ~clk;

    ed25519_sign_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_sk(req_sk), .req_pk(req_pk), .req_msg(req_msg),
        .gnt(gnt), .res_valid(res_valid), .res_id(res_id),
        .res_r(res_r), .res_s(res_s), .res_err(res_err),
        .core_sk(core_sk), .core_pk(core_pk), .core_m(core_m),
        .core_ena(core_ena), .core_ready(core_ready),
        .core_comp_done(core_comp_done), .core_r(core_r), .core_s(core_s)
    );

    // Signing-core stub, reset together with the arbiter.
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (rst) stub_cnt <= 0;
        else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_hang) begin
                stub_done <= 1'b1;
                core_r    <= core_sk ^ core_m;
                core_s    <= core_pk + 256'd1;
            end
        end else if (core_ena) stub_cnt <= stub_delay;
    end

    // Start-pulse monitor: total pulses and back-to-back pulses.
    always @(posedge clk) begin
        if (core_ena) ena_cnt <= ena_cnt + 1;
        if (core_ena && ena_prev) ena_dbl <= ena_dbl + 1;
        ena_prev <= core_ena;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] op_val(input logic [7:0] tag, input int i);
        logic [31:0] w;
        w = {tag, 8'(i), 16'hC0DE};
        return {8{w}};
    endfunction

    function automatic logic [255:0] exp_r(input int i);
        return op_val(8'h10, i) ^ op_val(8'h30, i);
    endfunction

    function automatic logic [255:0] exp_s(input int i);
        return op_val(8'h20, i) + 256'd1;
    endfunction

    task automatic load_ops();
        for (int i = 0; i < 4; i++) begin
            req_sk[256*i +: 256]  = op_val(8'h10, i);
            req_pk[256*i +: 256]  = op_val(8'h20, i);
            req_msg[256*i +: 256] = op_val(8'h30, i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input int limit, output bit got);
        got = 1'b0;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ena(input int limit, output bit got);
        got = 1'b0;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (core_ena) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0;
        repeat (3) tick();
        checks++; if (gnt !== 4'b0) begin fails++; $display("FAIL reset_gnt got %h want 0", gnt); end
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if (res_err !== 1'b0) begin fails++; $display("FAIL reset_res_err got %b want 0", res_err); end
        checks++; if (res_id !== 3'd0) begin fails++; $display("FAIL reset_res_id got %0d want 0", res_id); end
        checks++; if (core_ena !== 1'b0) begin fails++; $display("FAIL reset_core_ena got %b want 0", core_ena); end
        checks++; if ({res_r, res_s, core_sk, core_pk, core_m} !== '0) begin fails++; $display("FAIL reset_data some result/operand register nonzero"); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int order[5];
        int e0;
        bit got;
        order = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e0 = ena_cnt;
            wait_res(300, got);
            checks++; if (!got) begin fails++; $display("FAIL rr_timeout op %0d no res_valid", n); end
            checks++; if (res_id !== 3'(order[n])) begin fails++; $display("FAIL rr_order op %0d got id %0d want %0d", n, res_id, order[n]); end
            checks++; if (gnt !== 4'(1 << order[n])) begin fails++; $display("FAIL rr_gnt op %0d got %b want %b", n, gnt, 4'(1 << order[n])); end
            checks++; if (ena_cnt - e0 !== 1) begin fails++; $display("FAIL rr_ena op %0d got %0d pulses want 1", n, ena_cnt - e0); end
        end
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_priority();
        bit got;
        req = 4'b0010;
        wait_res(300, got);
        checks++; if (!got || res_id !== 3'd1) begin fails++; $display("FAIL prio_first got id %0d valid %b want 1", res_id, got); end
        req = 4'b1001;
        tick(); tick();
        checks++; if (gnt !== 4'b1000) begin fails++; $display("FAIL prio_gnt got %b want 1000", gnt); end
        wait_res(300, got);
        checks++; if (!got || res_id !== 3'd3) begin fails++; $display("FAIL prio_second got id %0d want 3", res_id); end
        req = 4'b0001;
        wait_res(300, got);
        checks++; if (!got || res_id !== 3'd0) begin fails++; $display("FAIL prio_third got id %0d want 0", res_id); end
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_single();
        int e0;
        bit got;
        e0 = ena_cnt;
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt got %b want 0100", gnt); end
        checks++; if (core_sk !== op_val(8'h10, 2) || core_m !== op_val(8'h30, 2)) begin fails++; $display("FAIL single_operands core_sk %h", core_sk[31:0]); end
        checks++; if (core_ena !== 1'b0) begin fails++; $display("FAIL single_ena_early got %b want 0", core_ena); end
        tick();
        checks++; if (core_ena !== 1'b1) begin fails++; $display("FAIL single_ena_latency got %b want 1", core_ena); end
        wait_res(200, got);
        checks++; if (!got || res_id !== 3'd2) begin fails++; $display("FAIL single_id got %0d want 2", res_id); end
        checks++; if (res_r !== exp_r(2) || res_s !== exp_s(2)) begin fails++; $display("FAIL single_result r %h s %h want r %h s %h", res_r[31:0], res_s[31:0], exp_r(2) & 256'hFFFFFFFF, exp_s(2) & 256'hFFFFFFFF); end
        checks++; if (res_err !== 1'b0) begin fails++; $display("FAIL single_err got %b want 0", res_err); end
        checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt_done got %b want 0100", gnt); end
        checks++; if (ena_cnt - e0 !== 1) begin fails++; $display("FAIL single_ena_count got %0d want 1", ena_cnt - e0); end
        req = '0;
        tick();
        checks++; if (res_valid !== 1'b0 || gnt !== 4'b0) begin fails++; $display("FAIL single_after valid %b gnt %b want 0 0", res_valid, gnt); end
        tick();
    endtask

    task automatic test_hold_operands();
        bit got;
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL hold_gnt got %b want 0001", gnt); end
        req = '0;
        req_sk[255:0]  = op_val(8'h77, 0);
        req_msg[255:0] = op_val(8'h88, 0);
        repeat (3) tick();
        checks++; if (core_sk !== op_val(8'h10, 0) || core_m !== op_val(8'h30, 0)) begin fails++; $display("FAIL hold_operands core_sk %h", core_sk[31:0]); end
        wait_res(200, got);
        checks++; if (!got || res_id !== 3'd0 || res_r !== exp_r(0)) begin fails++; $display("FAIL hold_result valid %b id %0d r %h", got, res_id, res_r[31:0]); end
        load_ops();
        repeat (2) tick();
    endtask

    task automatic test_ready_stall();
        bit got;
        bit bad;
        core_ready = 1'b0;
        req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL stall_gnt got %b want 0010", gnt); end
        spur = 1'b1;
        tick();
        spur = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (core_ena || res_valid) bad = 1'b1;
            tick();
        end
        checks++; if (bad) begin fails++; $display("FAIL stall_quiet got activity want none"); end
        core_ready = 1'b1;
        tick();
        checks++; if (core_ena !== 1'b1) begin fails++; $display("FAIL stall_ena got %b want 1", core_ena); end
        tick();
        checks++; if (core_ena !== 1'b0) begin fails++; $display("FAIL stall_ena_width got %b want 0", core_ena); end
        wait_res(200, got);
        checks++; if (!got || res_id !== 3'd1) begin fails++; $display("FAIL stall_result id %0d want 1", res_id); end
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_rst_busy();
        bit got;
        bit bad;
        req = 4'b0001;
        wait_ena(10, got);
        checks++; if (!got) begin fails++; $display("FAIL rstbusy_start no core_ena"); end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        checks++; if (gnt !== 4'b0 || res_valid !== 1'b0 || core_ena !== 1'b0 || res_id !== 3'd0) begin fails++; $display("FAIL rstbusy_ctrl gnt %b valid %b ena %b id %0d want 0", gnt, res_valid, core_ena, res_id); end
        checks++; if (core_sk !== '0 || core_m !== '0) begin fails++; $display("FAIL rstbusy_operands core_sk %h want 0", core_sk[31:0]); end
        bad = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (res_valid) bad = 1'b1;
        end
        checks++; if (bad) begin fails++; $display("FAIL rstbusy_abandon got res_valid want none"); end
        req = 4'b1010;
        wait_res(200, got);
        checks++; if (!got || res_id !== 3'd1 || res_r !== exp_r(1)) begin fails++; $display("FAIL rstbusy_next valid %b id %0d want 1", got, res_id); end
        req = '0;
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        bit got;
        int t;
        stub_hang = 1'b1;
        req = 4'b0001;
        wait_ena(10, got);
        checks++; if (!got) begin fails++; $display("FAIL tmo_start no core_ena"); end
`ifdef ED25519_SIGN_ARB_TIMEOUT_EN
        t = 0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            t++;
            if (res_valid) begin got = 1'b1; break; end
        end
        checks++; if (!got || t !== 100) begin fails++; $display("FAIL tmo_latency got %0d cycles want 100", t); end
        checks++; if (res_err !== 1'b1 || res_id !== 3'd0) begin fails++; $display("FAIL tmo_err err %b id %0d want 1 0", res_err, res_id); end
        checks++; if (res_r !== '0 || res_s !== '0) begin fails++; $display("FAIL tmo_data got nonzero r/s want 0"); end
        req = '0;
        repeat (2) tick();
`else
        t = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (res_valid) t++;
        end
        checks++; if (t !== 0) begin fails++; $display("FAIL tmo_none got %0d res_valid want 0", t); end
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
        stub_hang = 1'b0;
    endtask

    initial begin
        load_ops();
        test_reset();
        test_round_robin();
        test_priority();
        test_single();
        test_hold_operands();
        test_ready_stall();
        test_rst_busy();
        test_timeout();
        checks++; if (ena_dbl !== 0) begin fails++; $display("FAIL ena_back_to_back got %0d want 0", ena_dbl); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
